// File: rtl/rs485_slave_node.sv
// rtl/rs485_slave_node.sv - RS-485 node: 6-byte command receiver, 9-byte response transmitter
module rs485_slave_node #(
  parameter int          CLK_DIV   = 2604,
  parameter logic [7:0]  NODE_ADDR = 8'h01,
  parameter int          TURN_BITS = 2,
  parameter int          GAP_BITS  = 20
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic        en,
  input  logic [55:0] rsp_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [23:0] cmd_arg,
  output logic        busy,
  output logic        err
);

  localparam int GAP_CYC  = GAP_BITS * CLK_DIV;
  localparam int TURN_CYC = TURN_BITS * CLK_DIV;
  localparam int MAX_CYC  = (GAP_CYC > TURN_CYC) ? ((GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV)
                                                 : ((TURN_CYC > CLK_DIV) ? TURN_CYC : CLK_DIV);
  localparam int CW       = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_TURN, S_TX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d, gap_q, gap_d;
  logic [3:0]    bit_q, bit_d, byte_q, byte_d;
  logic          in_char_q, in_char_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [47:0]   cmd_buf_q, cmd_buf_d;
  logic [71:0]   rsp_buf_q, rsp_buf_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    cmd_op_q, cmd_op_d;
  logic [23:0]   cmd_arg_q, cmd_arg_d;
  logic          en_q, en_d, busy_q, busy_d;
  logic          rx_fall;

  function automatic logic [7:0] byte_sum(input logic [71:0] v, input int n);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) if (i < n) s = s + v[i*8 +: 8];
    return s;
  endfunction

  assign rx_fall = prev_q & ~sync2_q;

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      in_char_q <= 1'b0;
      rx_sh_q   <= '0;
      cmd_buf_q <= '0;
      rsp_buf_q <= '0;
      tx_sh_q   <= '0;
      cmd_op_q  <= '0;
      cmd_arg_q <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      in_char_q <= in_char_d;
      rx_sh_q   <= rx_sh_d;
      cmd_buf_q <= cmd_buf_d;
      rsp_buf_q <= rsp_buf_d;
      tx_sh_q   <= tx_sh_d;
      cmd_op_q  <= cmd_op_d;
      cmd_arg_q <= cmd_arg_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    in_char_d = in_char_q;
    rx_sh_d   = rx_sh_q;
    cmd_buf_d = cmd_buf_q;
    rsp_buf_d = rsp_buf_q;
    tx_sh_d   = tx_sh_q;
    cmd_op_d  = cmd_op_q;
    cmd_arg_d = cmd_arg_q;
    en_d      = en_q;
    busy_d    = busy_q;
    cmd_valid = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d   = S_RX;
          in_char_d = 1'b1;
          cnt_d     = CW'(CLK_DIV / 2 - 1);
          bit_d     = '0;
          byte_d    = '0;
          gap_d     = '0;
        end
      end
      S_RX: begin
        if (in_char_q) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = CW'(CLK_DIV - 1);
            if (bit_q == 4'd0) begin
              // Line high at mid start bit: false start, resume waiting
              if (sync2_q) begin
                in_char_d = 1'b0;
                if (byte_q == 4'd0) state_d = S_IDLE;
              end else begin
                bit_d = 4'd1;
              end
            end else if (bit_q != 4'd9) begin
              rx_sh_d = {sync2_q, rx_sh_q[7:1]};
              bit_d   = bit_q + 4'd1;
            end else if (!sync2_q) begin
              err     = 1'b1;
              state_d = S_IDLE;
            end else begin
              cmd_buf_d = {rx_sh_q, cmd_buf_q[47:8]};
              in_char_d = 1'b0;
              gap_d     = '0;
              if (byte_q == 4'd5) state_d = S_CHECK;
              else byte_d = byte_q + 4'd1;
            end
          end
        end else if (gap_q == CW'(GAP_CYC - 1)) begin
          // Timeout wins over a coincident start edge
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
          if (rx_fall) begin
            in_char_d = 1'b1;
            cnt_d     = CW'(CLK_DIV / 2 - 1);
            bit_d     = '0;
          end
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (byte_sum({24'h0, cmd_buf_q}, 5) != cmd_buf_q[47:40]) begin
          err = 1'b1;
        end else if (cmd_buf_q[7:0] == NODE_ADDR || cmd_buf_q[7:0] == 8'hFF) begin
          cmd_valid = 1'b1;
          cmd_op_d  = cmd_buf_q[15:8];
          cmd_arg_d = cmd_buf_q[39:16];
          rsp_buf_d = {byte_sum({8'h0, rsp_data, NODE_ADDR}, 8), rsp_data, NODE_ADDR};
          if (cmd_buf_q[7:0] == NODE_ADDR) begin
            busy_d  = 1'b1;
            en_d    = 1'b1;
            cnt_d   = CW'(TURN_CYC - 1);
            state_d = S_TURN;
          end
        end
      end
      S_TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          tx_sh_d   = {1'b1, rsp_buf_q[7:0], 1'b0};
          rsp_buf_d = {8'h0, rsp_buf_q[71:8]};
          cnt_d     = CW'(CLK_DIV - 1);
          bit_d     = '0;
          byte_d    = '0;
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = CW'(CLK_DIV - 1);
          if (bit_q != 4'd9) begin
            tx_sh_d = {1'b1, tx_sh_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end else if (byte_q == 4'd8) begin
            state_d = S_DONE;
          end else begin
            tx_sh_d   = {1'b1, rsp_buf_q[7:0], 1'b0};
            rsp_buf_d = {8'h0, rsp_buf_q[71:8]};
            byte_d    = byte_q + 4'd1;
            bit_d     = '0;
          end
        end
      end
      S_DONE: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx      = (state_q == S_TX) ? tx_sh_q[0] : 1'b1;
  assign en      = en_q;
  assign busy    = busy_q;
  assign cmd_op  = cmd_op_q;
  assign cmd_arg = cmd_arg_q;

endmodule
